mac_acc_seq: RTL and testbench
==============================

// Module: mac_acc_seq
// PURPOSE
//  Folded, backpressure-aware MAC: computes dot(W,X)+bias over N_INPUT signed pairs, LANES pairs per beat.
//  Accumulates ceil(N_INPUT/LANES) beats into a wide accumulator, then applies shift, optional ReLU and saturation.
//  Successor to the fixed 49-wide single-shot MAC; sits between the conv window/weight fetch and the layer writeback.
// PARAMETERS
//  WIDTH      32  signed operand width (weights, pixels, bias)
//  N_INPUT    49  products per output (vector length)
//  LANES      7   multipliers per beat; BEATS = ceil(N_INPUT/LANES)
//  ACC_WIDTH  72  accumulator width; must be >= 2*WIDTH+$clog2(N_INPUT)+1
//  OUT_WIDTH  32  signed result width
//  SHIFT      0   arithmetic right shift applied to the accumulator before clipping
//  RELU_EN    0   1: negative post-shift values become 0
// PORTS
//  clk       in   1                clock
//  rst       in   1                synchronous, active-high reset
//  s_valid   in   1                beat valid
//  s_ready   out  1                beat accepted when s_valid&s_ready
//  s_weight  in   LANES x WIDTH    signed weights, lane l = element beat*LANES+l
//  s_img     in   LANES x WIDTH    signed pixels, same indexing
//  s_bias    in   WIDTH            signed bias, sampled only on beat 0
//  m_valid   out  1                result valid, held until m_ready
//  m_ready   in   1                downstream accept
//  m_sum     out  OUT_WIDTH        signed result, stable while m_valid
//  m_sat     out  1                result was clipped (either rail)
// BEHAVIOUR
//  Reset: s_ready=0, m_valid=0, m_sum=0, m_sat=0, beat counter=0, acc=0, pipeline valids=0, FSM=ACCEPT.
//    s_ready=1 in the first cycle after rst deasserts. Reset mid-vector discards partial work, with no output.
//  FSM (encoded in pkg):
//    ACCEPT: s_ready=1. Each accepted beat increments beat_cnt. The beat with beat_cnt==BEATS-1 sets beat_cnt to 0 and goes to DRAIN.
//    DRAIN:  s_ready=0. Waits for the final beat to leave the pipeline, then goes to HOLD.
//    HOLD:   m_valid=1. On m_valid&m_ready: m_valid goes to 0 next cycle, acc clears, goes to ACCEPT.
//  Pipeline (one register per stage):
//    P1 lane products, WIDTH x WIDTH -> 2*WIDTH signed.
//    P2 lane adder tree sum, sign-extended to ACC_WIDTH.
//    P3 accumulate: beat 0 loads tree+bias, other beats add tree to acc.
//    P4 output: shift, ReLU, clip; m_sum, m_sat, m_valid registered.
//  Latency: m_valid is high 4 cycles after the edge that accepts the last beat.
//  Gaps in s_valid are legal; bubbles do not accumulate.
//  Lane masking: lanes with beat*LANES+l >= N_INPUT contribute 0, whatever the input values.
//  Clip: if shifted value > 2^(OUT_WIDTH-1)-1, m_sum = max and m_sat=1.
//    If shifted value < -2^(OUT_WIDTH-1), m_sum = min and m_sat=1. ReLU zeroing does not set m_sat.
//  Accumulator never wraps for legal ACC_WIDTH; elaboration asserts the width rule.
//  s_valid while s_ready=0 is ignored; the source must hold data (AXI-style).
//  m_ready while m_valid=0 has no effect. m_sum and m_sat hold their last value after the handshake.
//  BEATS==1: the single beat is both first and last.
// STRUCTURE
//  mac_pkg: state enum (ACCEPT, DRAIN, HOLD), function clip_sat(acc)->{sat,val}, localparam helpers for BEATS and $clog2.
//  Sub-module mac_lane_tree #(WIDTH,LANES): registered multipliers plus registered adder tree (P1,P2), with a lane-mask input.
//  Top level holds the FSM, beat counter, accumulator and output stage.
// TESTING
//  1 All W=1, X=1, bias=0, N=49, LANES=7, 7 back-to-back beats -> m_sum=49, m_sat=0, m_valid 4 cycles after beat 7.
//  2 W=i, X=-1, bias=100, s_valid gaps after each beat -> m_sum = 100-1176 = -1076; no extra beats consumed.
//  3 W=X=0x7FFFFFFF all lanes -> m_sum=0x7FFFFFFF, m_sat=1. Negated weights -> 0x80000000, m_sat=1.
//    Same negated case with RELU_EN=1 -> m_sum=0, m_sat=0.
//  4 m_ready low for 10 cycles in HOLD -> m_sum stable, s_ready=0 throughout. Next vector accepted the cycle after handshake.
//  5 N=50, LANES=7, last-beat lanes 1..6 driven with 0x55 garbage, rest 1 -> m_sum=50 (masking).
//  6 rst pulsed after beat 3, then a clean vector of ones -> exactly one output m_sum=49; s_ready=0 during rst.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the folded MAC: FSM states, beat/width
// arithmetic, and the output saturation function.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        HOLD
    } state_t;

    // Widest value clip_sat can take; the accumulator must be narrower.
    localparam int unsigned CLIP_W = 256;

    // sat sits in the LSB so a caller can size-cast to {val[OUT-1:0], sat}.
    typedef struct packed {
        logic signed [CLIP_W-1:0] val;
        logic                     sat;
    } clip_t;

    function automatic int unsigned beats_of(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int unsigned acc_min_width(input int unsigned width, input int unsigned n);
        return 2 * width + $clog2(n) + 1;
    endfunction

    function automatic clip_t clip_sat(input logic signed [CLIP_W-1:0] v, input int unsigned out_w);
        logic signed [CLIP_W-1:0] hi;
        logic signed [CLIP_W-1:0] lo;
        clip_t r;
        hi    = CLIP_W'(1) <<< (out_w - 1);
        lo    = -hi;
        hi    = hi - CLIP_W'(1);
        r.val = v;
        r.sat = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Lane multipliers and adder tree: P1 registers masked lane products,
// P2 registers their signed sum.
module mac_lane_tree #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 7,
    localparam int unsigned SUM_W = 2 * WIDTH + $clog2(LANES) + 1
) (
    input  logic                         clk,
    input  logic [LANES-1:0]             mask,
    input  logic [LANES-1:0][WIDTH-1:0]  weight,
    input  logic [LANES-1:0][WIDTH-1:0]  img,
    output logic signed [SUM_W-1:0]      sum
);

    logic signed [2*WIDTH-1:0] prod [LANES];
    logic signed [SUM_W-1:0]   tree;

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            prod[l] <= mask[l] ? (2*WIDTH)'($signed(weight[l])) * (2*WIDTH)'($signed(img[l])) : '0;
        end
    end

    always_comb begin
        tree = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            tree = tree + SUM_W'(prod[l]);
        end
    end

    always_ff @(posedge clk) begin
        sum <= tree;
    end

endmodule

// File: rtl/mac_acc_seq.sv
// Folded backpressure-aware MAC: accumulates BEATS beats of LANES products
// plus bias, then shifts, optionally rectifies and saturates the result.
module mac_acc_seq
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_INPUT   = 49,
    parameter int unsigned LANES     = 7,
    parameter int unsigned ACC_WIDTH = 72,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned SHIFT     = 0,
    parameter bit          RELU_EN   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [LANES-1:0][WIDTH-1:0]  s_weight,
    input  logic [LANES-1:0][WIDTH-1:0]  s_img,
    input  logic [WIDTH-1:0]             s_bias,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_WIDTH-1:0]         m_sum,
    output logic                         m_sat
);

    localparam int unsigned BEATS  = beats_of(N_INPUT, LANES);
    localparam int unsigned CW     = cnt_width(BEATS);
    localparam int unsigned TREE_W = 2 * WIDTH + $clog2(LANES) + 1;

    if (ACC_WIDTH < acc_min_width(WIDTH, N_INPUT)) begin : g_acc_narrow
        $error("ACC_WIDTH too narrow for WIDTH and N_INPUT");
    end
    if (ACC_WIDTH >= CLIP_W || OUT_WIDTH > ACC_WIDTH || TREE_W > ACC_WIDTH || LANES > N_INPUT) begin : g_bad_cfg
        $error("unsupported mac_acc_seq width/lane configuration");
    end

    state_t                        state, state_n;
    logic [CW-1:0]                 beat_cnt;
    logic                          accept, last_beat;
    logic [LANES-1:0]              mask;
    logic signed [TREE_W-1:0]      tree;
    logic                          v1, first1, last1, v2, first2, last2, done3;
    logic signed [WIDTH-1:0]       bias_q;
    logic signed [ACC_WIDTH-1:0]   acc, shifted, relu_val;

    assign accept    = s_valid & s_ready;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ACCEPT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ACCEPT:  if (accept && last_beat) state_n = DRAIN;
            DRAIN:   if (done3)               state_n = HOLD;
            HOLD:    if (m_ready)             state_n = ACCEPT;
            default:                          state_n = ACCEPT;
        endcase
    end

    always_comb begin
        s_ready = (state == ACCEPT) && !rst;
        m_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst)         beat_cnt <= '0;
        else if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
    end

    // Lanes past the end of the vector on the final beat contribute nothing.
    always_comb begin
        mask = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            mask[l] = (32'(beat_cnt) * LANES + l) < N_INPUT;
        end
    end

    mac_lane_tree #(.WIDTH(WIDTH), .LANES(LANES)) u_tree (
        .clk    (clk),
        .mask   (mask),
        .weight (s_weight),
        .img    (s_img),
        .sum    (tree)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, first1, last1, v2, first2, last2, done3} <= '0;
        end else begin
            v1     <= accept;
            first1 <= accept && (beat_cnt == '0);
            last1  <= accept && last_beat;
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            done3  <= v2 && last2;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (beat_cnt == '0)) bias_q <= s_bias;
    end

    always_ff @(posedge clk) begin
        if (rst)                         acc <= '0;
        else if (state == HOLD && m_ready) acc <= '0;
        else if (v2)                     acc <= (first2 ? ACC_WIDTH'(bias_q) : acc) + ACC_WIDTH'(tree);
    end

    always_comb begin
        shifted  = acc >>> SHIFT;
        relu_val = (RELU_EN && shifted[ACC_WIDTH-1]) ? '0 : shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_sum <= '0;
            m_sat <= 1'b0;
        end else if (state == DRAIN && done3) begin
            {m_sum, m_sat} <= (OUT_WIDTH + 1)'(clip_sat(CLIP_W'(relu_val), OUT_WIDTH));
        end
    end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Scoreboard bench for mac_acc_seq: three instances (plain N=49, ReLU N=49,
// plain N=50) share clock and reset; expected results are queued per instance.
module tb_mac_acc_seq;

    localparam int W  = 32;
    localparam int L  = 7;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                s_valid  [NI];
    logic                s_ready  [NI];
    logic                m_valid  [NI];
    logic                m_ready  [NI];
    logic                m_sat    [NI];
    logic [L-1:0][W-1:0] s_weight [NI];
    logic [L-1:0][W-1:0] s_img    [NI];
    logic [W-1:0]        s_bias   [NI];
    logic [W-1:0]        m_sum    [NI];

    logic [W:0] exp_q [NI][$];
    logic [W:0] mon_e;
    int         w_vec [64];
    int         x_vec [64];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mac_acc_seq #(
            .WIDTH     (W),
            .N_INPUT   ((g == 2) ? 50 : 49),
            .LANES     (L),
            .ACC_WIDTH (72),
            .OUT_WIDTH (32),
            .SHIFT     (0),
            .RELU_EN   (g == 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .s_valid  (s_valid[g]),
            .s_ready  (s_ready[g]),
            .s_weight (s_weight[g]),
            .s_img    (s_img[g]),
            .s_bias   (s_bias[g]),
            .m_valid  (m_valid[g]),
            .m_ready  (m_ready[g]),
            .m_sum    (m_sum[g]),
            .m_sat    (m_sat[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: exact dot product in 128 bits, then ReLU (instance 1) and 32-bit clip.
    function automatic logic [W:0] model(input int g, input int n, input int bias);
        logic signed [127:0] s, hi, lo;
        s = bias;
        for (int i = 0; i < n; i++) s = s + (longint'(w_vec[i]) * longint'(x_vec[i]));
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        if (g == 1 && s < 0) return {1'b0, 32'd0};
        if (s > hi)          return {1'b1, 32'h7fff_ffff};
        if (s < lo)          return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    // Called #1 after a posedge; returns #1 after the posedge of the last beat (plus gaps).
    task automatic send(input int g, input int n, input int bias, input int gap, input int nb, input bit push);
        int beats, cnt, idx;
        beats = (n + L - 1) / L;
        if (push) exp_q[g].push_back(model(g, n, bias));
        for (int b = 0; b < nb && b < beats; b++) begin
            for (int l = 0; l < L; l++) begin
                idx = b * L + l;
                s_weight[g][l] = (idx < n) ? w_vec[idx] : 32'h55;
                s_img[g][l]    = (idx < n) ? x_vec[idx] : 32'h55;
            end
            s_bias[g]  = (b == 0) ? bias : 32'h0bad_0bad;
            s_valid[g] = 1'b1;
            cnt = 0;
            while (!s_ready[g] && cnt < 100) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (!s_ready[g]) check($sformatf("ready_timeout%0d", g), s_ready[g], 1);
            @(posedge clk); #1;
            s_valid[g] = 1'b0;
            if (b == beats - 1) check($sformatf("drain_ready%0d", g), s_ready[g], 0);
            for (int k = 0; k < gap; k++) begin
                s_weight[g][0] = $urandom;
                s_img[g][0]    = $urandom;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_valid(input int g, output int c);
        c = 1;
        while (!m_valid[g] && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("idle", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);
    endtask

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < 64; i++) begin
            w_vec[i] = wv;
            x_vec[i] = xv;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < NI; g++) begin
                if (m_valid[g] && m_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_out%0d", g), m_valid[g], 0);
                    end else begin
                        mon_e = exp_q[g].pop_front();
                        check($sformatf("sum%0d", g), m_sum[g], mon_e[W-1:0]);
                        check($sformatf("sat%0d", g), m_sat[g], mon_e[W]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            s_valid[g]  = 1'b0;
            m_ready[g]  = 1'b1;
            s_weight[g] = '0;
            s_img[g]    = '0;
            s_bias[g]   = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_valid%0d", g), m_valid[g], 0);
            check($sformatf("rst_sum%0d", g),   m_sum[g],   0);
            check($sformatf("rst_sat%0d", g),   m_sat[g],   0);
            check($sformatf("rst_ready%0d", g), s_ready[g], 0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", s_ready[0], 1);
        @(posedge clk); #1;

        // All ones, back-to-back beats, and output latency.
        fill(1, 1);
        send(0, 49, 0, 0, 7, 1'b1);
        wait_valid(0, cyc);
        check("latency", 64'(cyc), 4);

        // W=i, X=-1, bias 100 with bubbles between beats: 100-1176.
        fill(0, -1);
        for (int i = 0; i < 49; i++) w_vec[i] = i;
        send(0, 49, 100, 2, 7, 1'b1);

        // Saturation at both rails, and ReLU clamping the negative case.
        fill(32'h7fff_ffff, 32'h7fff_ffff);
        send(0, 49, 0, 0, 7, 1'b1);
        fill(-32'sh7fff_ffff, 32'h7fff_ffff);
        send(0, 49, 0, 0, 7, 1'b1);
        send(1, 49, 0, 0, 7, 1'b1);
        fill(1, 1);
        send(1, 49, 0, 0, 7, 1'b1);

        // Exactly on the rails: no saturation.
        fill(0, 0);
        send(0, 49, 32'h7fff_ffff, 0, 7, 1'b1);
        send(0, 49, 32'h8000_0000, 0, 7, 1'b1);

        // N=50: final beat lanes 1..6 carry garbage that must be masked.
        fill(1, 1);
        send(2, 50, 0, 0, 8, 1'b1);
        for (int i = 0; i < 50; i++) begin
            w_vec[i] = i;
            x_vec[i] = i;
        end
        send(2, 50, -7, 1, 8, 1'b1);

        // Random small signed vectors with random gaps.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 49; i++) begin
                w_vec[i] = int'($urandom_range(0, 2000)) - 1000;
                x_vec[i] = int'($urandom_range(0, 2000)) - 1000;
            end
            send(0, 49, int'($urandom_range(0, 200000)) - 100000, int'($urandom_range(0, 2)), 7, 1'b1);
        end

        // Backpressure in HOLD, then next vector on the cycle after the handshake.
        wait_idle();
        m_ready[0] = 1'b0;
        fill(1, 1);
        send(0, 49, 7, 0, 7, 1'b1);
        wait_valid(0, cyc);
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", m_valid[0], 1);
            check("hold_sum",   m_sum[0],   32'd56);
            check("hold_ready", s_ready[0], 0);
            @(posedge clk); #1;
        end
        m_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_low",    m_valid[0], 0);
        check("sum_after_hs",    m_sum[0],   32'd56);
        check("accept_after_hs", s_ready[0], 1);
        fill(2, 3);
        send(0, 49, -300, 0, 7, 1'b1);

        // Reset mid-vector discards partial work; a clean vector follows.
        wait_idle();
        fill(1, 1);
        send(0, 49, 0, 0, 3, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", s_ready[0], 0);
        @(posedge clk); #1;
        check("rst_mid_ready2", s_ready[0], 0);
        @(posedge clk); #1;
        check("rst_mid_valid", m_valid[0], 0);
        rst = 1'b0;
        #1;
        check("ready_post_mid_rst", s_ready[0], 1);
        send(0, 49, 0, 0, 7, 1'b1);

        wait_idle();
        repeat (6) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
